pot_scan_sched: RTL and testbench
=================================

# pot_scan_sched

Conversion scheduler for the shared A2D serial interface on the Equalizer board. Sweeps the six slide-pot channels (LP, B1, B2, B3, HP band gains and VOLUME) in fixed round-robin order, holds the latest 12-bit result for each, and shares the same converter with one auxiliary one-shot requester. Sits between the A2D SPI interface block (which drives A2D_SS_n/SCLK/MOSI/MISO toward the ADC128S) and the band-scaling / volume datapath.

## Interface

- GAP_CYC, 1024: idle clk cycles between the end of one conversion and the next strt_cnv.
- TIMEOUT_CYC, 4096: max clk cycles waited for cnv_cmplt before abandoning a conversion.
- CH_MAP, {3'd7,3'd3,3'd2,3'd4,3'd0,3'd1}: A2D channel per sweep index, 3 bits each; index 0 (LP) in bits [2:0], index 5 (VOL) in bits [17:15].
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- strt_cnv  out  1  one-cycle pulse to the A2D interface requesting a conversion.
- chnnl  out  3  channel for the current conversion; stable from strt_cnv until the conversion finishes.
- cnv_cmplt  in  1  one-cycle pulse from the A2D interface; res valid in the same cycle.
- res  in  12  conversion result.
- aux_req  in  1  auxiliary request; sampled each cycle; ignored while aux_busy=1.
- aux_chnnl  in  3  auxiliary channel; captured in the cycle aux_req is accepted.
- aux_busy  out  1  auxiliary request pending or in flight.
- aux_done  out  1  one-cycle pulse; aux_res updated in the same cycle.
- aux_res  out  12  last auxiliary result.
- LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, VOLUME  out  12 each  latest pot results.
- pots_vld  out  1  set once every pot has been stored at least once since reset.
- a2d_err  out  1  sticky; set on any timeout.

## Operation

- States: GAP, REQ, WAIT, STORE.
- GAP: counter runs 0..GAP_CYC-1; at terminal count go to REQ. Counter cleared on entry.
- REQ (1 cycle): arbitrate, drive chnnl, assert strt_cnv, go to WAIT.
  - aux_pend=1 and previous slot was not aux -> serve aux (chnnl=latched aux_chnnl); sweep index unchanged.
  - Otherwise -> serve pot at sweep index idx (chnnl=CH_MAP[3*idx+:3]).
  - Aux never served in two consecutive slots; pots are guaranteed every other slot.
- WAIT: timeout counter runs. On cnv_cmplt go to STORE with res registered. At TIMEOUT_CYC cycles without cnv_cmplt: set a2d_err and go to GAP.
  - Pot timeout: register unchanged; idx not advanced, so the same channel is retried.
  - Aux timeout: aux_done pulses, aux_res unchanged, aux_pend cleared.
- STORE (1 cycle): write registered result to the target, then go to GAP.
  - Pot: write the register for idx. idx advances 0->5, 5 wraps to 0. Set the per-index stored bit.
  - Aux: aux_res <= result, aux_done=1, aux_pend cleared.
- pots_vld = AND of the six stored bits; once set, stays set until rst.
- aux_busy = aux_pend | (aux slot in REQ/WAIT/STORE). aux_req accepted only when aux_busy=0.
- cnv_cmplt outside WAIT: ignored.
- aux_req in the same cycle REQ arbitrates: not seen by that REQ; takes the next slot.

## Timing

- rst=1 (any state, including mid-conversion): state=GAP, counters=0, idx=0, all gain/VOLUME/aux_res=12'h000, pots_vld=0, a2d_err=0, aux_busy=0, strt_cnv=0, aux_done=0, chnnl=3'd0. Any in-flight cnv_cmplt after rst is ignored.
- First strt_cnv: GAP_CYC+1 cycles after the first cycle with rst=0 (GAP_CYC in GAP, then REQ).
- cnv_cmplt at cycle t -> target register / aux_res visible at t+2 (STORE at t+1, register update at its edge); aux_done high in cycle t+1.
- Slot period = GAP_CYC + 1 (REQ) + A2D latency + 1 (STORE).
- aux_req accepted at t -> aux_busy=1 from t+1.

## Test plan

- Sweep order (GAP_CYC=16, A2D model answering res={9'h0,chnnl} after 40 cycles): six strt_cnv with chnnl 1,0,4,2,3,7 -> LP_gain=1, B1_gain=0, B2_gain=4, B3_gain=2, HP_gain=3, VOLUME=7. pots_vld rises only after the VOLUME store; the seventh request is chnnl=1.
- Aux arbitration: aux_req with aux_chnnl=5 during a pot WAIT -> next slot chnnl=5, aux_done pulses with aux_res=5, sweep resumes at the next pot index. A second aux_req while aux_busy=1 is ignored.
- Aux back-to-back: aux_req re-asserted the cycle after aux_done -> exactly one pot slot runs before the next aux slot.
- Timeout (TIMEOUT_CYC=64, model silent for chnnl=4) -> a2d_err=1 after 64 WAIT cycles, B2_gain unchanged, next strt_cnv retries chnnl=4.
- Reset mid-WAIT: rst pulse while chnnl=2 is in flight, model returns cnv_cmplt 3 cycles later -> ignored; all outputs at reset values; first post-reset strt_cnv is chnnl=1 after GAP_CYC+1 cycles.
- Stray cnv_cmplt during GAP -> no register change, no state change.

Source files
------------

// File: rtl/pot_scan_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pot_scan_sched: round-robin A2D scheduler for the six slide pots, shared   |
// | with one auxiliary one-shot requester. Holds the latest result per pot.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pot_scan_sched #(
  parameter int          GAP_CYC     = 1024,
  parameter int          TIMEOUT_CYC = 4096,
  parameter logic [17:0] CH_MAP      = {3'd7, 3'd3, 3'd2, 3'd4, 3'd0, 3'd1}
) (
  input  logic        clk,
  input  logic        rst,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic        aux_req,
  input  logic [2:0]  aux_chnnl,
  output logic        aux_busy,
  output logic        aux_done,
  output logic [11:0] aux_res,
  output logic [11:0] LP_gain,
  output logic [11:0] B1_gain,
  output logic [11:0] B2_gain,
  output logic [11:0] B3_gain,
  output logic [11:0] HP_gain,
  output logic [11:0] VOLUME,
  output logic        pots_vld,
  output logic        a2d_err
);

  localparam int MAX_CYC = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  state_t       state;
  logic [CW-1:0] cnt;
  logic [2:0]   idx;
  logic         aux_pend;
  logic [2:0]   aux_ch;
  logic         slot_aux;   // type of the current slot; during GAP, of the previous one
  logic [11:0]  res_q;
  logic [11:0]  gain [0:5];
  logic [5:0]   stored;
  logic [2:0]   ch_tbl [0:7];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ch
      if (gi < 6) begin : g_map
        assign ch_tbl[gi] = CH_MAP[3*gi +: 3];
      end else begin : g_pad
        assign ch_tbl[gi] = 3'd0;
      end
    end
  endgenerate

  assign aux_busy = aux_pend | (slot_aux & (state != ST_GAP));
  assign pots_vld = &stored;
  assign LP_gain  = gain[0];
  assign B1_gain  = gain[1];
  assign B2_gain  = gain[2];
  assign B3_gain  = gain[3];
  assign HP_gain  = gain[4];
  assign VOLUME   = gain[5];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_GAP;
      cnt      <= '0;
      idx      <= 3'd0;
      aux_pend <= 1'b0;
      aux_ch   <= 3'd0;
      slot_aux <= 1'b0;
      res_q    <= 12'h000;
      stored   <= 6'b0;
      a2d_err  <= 1'b0;
      strt_cnv <= 1'b0;
      chnnl    <= 3'd0;
      aux_done <= 1'b0;
      aux_res  <= 12'h000;
      for (int i = 0; i < 6; i++) gain[i] <= 12'h000;
    end else begin
      strt_cnv <= 1'b0;
      aux_done <= 1'b0;
      if (aux_req && !aux_busy) begin
        aux_pend <= 1'b1;
        aux_ch   <= aux_chnnl;
      end
      case (state)
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state    <= ST_REQ;
            cnt      <= '0;
            strt_cnv <= 1'b1;
            // aux may not take two slots in a row, so pots get every other slot
            if (aux_pend && !slot_aux) begin
              slot_aux <= 1'b1;
              chnnl    <= aux_ch;
            end else begin
              slot_aux <= 1'b0;
              chnnl    <= ch_tbl[idx];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REQ: begin
          state <= ST_WAIT;
          cnt   <= '0;
        end
        ST_WAIT: begin
          if (cnv_cmplt) begin
            res_q    <= res;
            state    <= ST_STORE;
            cnt      <= '0;
            aux_done <= slot_aux;
          end else if (cnt == TO_LAST) begin
            a2d_err <= 1'b1;
            state   <= ST_GAP;
            cnt     <= '0;
            if (slot_aux) begin
              aux_done <= 1'b1;
              aux_pend <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STORE: begin
          state <= ST_GAP;
          cnt   <= '0;
          if (slot_aux) begin
            aux_res  <= res_q;
            aux_pend <= 1'b0;
          end else begin
            gain[idx]   <= res_q;
            stored[idx] <= 1'b1;
            idx         <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
          end
        end
        default: state <= ST_GAP;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pot_scan_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pot_scan_sched: directed + randomized bench with a slot-level model.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pot_scan_sched;
  localparam int G = 16;
  localparam int T = 64;

  logic        clk = 1'b0, rst = 1'b1;
  logic        strt_cnv, cnv_cmplt = 1'b0, aux_req = 1'b0;
  logic [2:0]  chnnl, aux_chnnl = 3'd0;
  logic [11:0] res = 12'h000, aux_res;
  logic        aux_busy, aux_done, pots_vld, a2d_err;
  logic [11:0] LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, VOLUME;

  pot_scan_sched #(.GAP_CYC(G), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res), .aux_req(aux_req), .aux_chnnl(aux_chnnl),
    .aux_busy(aux_busy), .aux_done(aux_done), .aux_res(aux_res),
    .LP_gain(LP_gain), .B1_gain(B1_gain), .B2_gain(B2_gain), .B3_gain(B3_gain),
    .HP_gain(HP_gain), .VOLUME(VOLUME), .pots_vld(pots_vld), .a2d_err(a2d_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;

  // Slot-level model: when the next request is due, what is in flight, what gets stored.
  int          pot_tab [6] = '{1, 0, 4, 2, 3, 7};
  bit          mvalid = 0;
  int          next_req = -1, req_cyc = 0, st_cyc = 0, m_idx = 0;
  bit          inflight, st_pend, st_aux, flight_aux, prev_aux, pend, aux_active;
  logic [11:0] st_val, m_auxres;
  logic [2:0]  m_auxch, e_chnnl;
  logic [11:0] m_gain [6];
  bit   [5:0]  m_stored;
  bit          e_strt, e_done, e_busy, e_err;

  // A2D responder and observation log
  bit          resp_pend = 0, rand_mode = 0, stray_v = 0, saw_done = 0;
  int          resp_cyc = 0, silent_ch = 8, rc = 0;
  logic [11:0] resp_val = 12'h000;
  int          strt_log[$], strt_cyc_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit busy_c, pend_c, serve;
    if (rst) begin
      next_req = cyc + 1 + G;
      inflight = 0; st_pend = 0; prev_aux = 0; pend = 0; aux_active = 0;
      m_idx = 0; m_stored = '0; m_auxres = 12'h000; m_auxch = 3'd0;
      for (int i = 0; i < 6; i++) m_gain[i] = 12'h000;
      e_strt = 0; e_done = 0; e_busy = 0; e_err = 0; e_chnnl = 3'd0;
      mvalid = 1;
    end else begin
      busy_c = e_busy; pend_c = pend;
      e_strt = 0; e_done = 0;
      if (st_pend && cyc == st_cyc) begin
        if (st_aux) begin
          m_auxres = st_val; pend = 0; aux_active = 0;
        end else begin
          m_gain[m_idx] = st_val; m_stored[m_idx] = 1'b1; m_idx = (m_idx + 1) % 6;
        end
        st_pend = 0;
      end
      if (inflight && cyc > req_cyc) begin
        if (cnv_cmplt) begin
          st_pend = 1; st_cyc = cyc + 1; st_val = res; st_aux = flight_aux;
          e_done = flight_aux; inflight = 0; next_req = cyc + 2 + G;
        end else if (cyc == req_cyc + T) begin
          e_err = 1;
          if (flight_aux) begin e_done = 1; pend = 0; aux_active = 0; end
          inflight = 0; next_req = cyc + 1 + G;
        end
      end
      if (cyc + 1 == next_req) begin
        serve = pend_c && !prev_aux;
        e_strt = 1;
        e_chnnl = serve ? m_auxch : 3'(pot_tab[m_idx]);
        inflight = 1; req_cyc = cyc + 1; flight_aux = serve; prev_aux = serve;
        if (serve) aux_active = 1;
      end
      if (aux_req && !busy_c) begin pend = 1; m_auxch = aux_chnnl; end
      e_busy = pend || aux_active;
    end
  endtask

  task automatic tick();
    if (mvalid) begin
      check("strt_cnv", 32'(strt_cnv), 32'(e_strt));
      if (inflight) check("chnnl", 32'(chnnl), 32'(e_chnnl));
      check("aux_busy", 32'(aux_busy), 32'(e_busy));
      check("aux_done", 32'(aux_done), 32'(e_done));
      check("aux_res",  32'(aux_res),  32'(m_auxres));
      check("LP_gain",  32'(LP_gain),  32'(m_gain[0]));
      check("B1_gain",  32'(B1_gain),  32'(m_gain[1]));
      check("B2_gain",  32'(B2_gain),  32'(m_gain[2]));
      check("B3_gain",  32'(B3_gain),  32'(m_gain[3]));
      check("HP_gain",  32'(HP_gain),  32'(m_gain[4]));
      check("VOLUME",   32'(VOLUME),   32'(m_gain[5]));
      check("pots_vld", 32'(pots_vld), 32'(&m_stored));
      check("a2d_err",  32'(a2d_err),  32'(e_err));
    end
    if (strt_cnv === 1'b1) begin
      strt_log.push_back(int'(chnnl));
      strt_cyc_log.push_back(cyc);
      if (int'(chnnl) != silent_ch && !(rand_mode && $urandom_range(15) == 0)) begin
        resp_pend = 1;
        resp_cyc  = cyc + (rand_mode ? int'($urandom_range(1, 50)) : 40);
        resp_val  = rand_mode ? 12'($urandom) : {9'h0, chnnl};
      end
    end
    saw_done = (aux_done === 1'b1);
    cnv_cmplt = 1'b0;
    if (resp_pend && cyc == resp_cyc) begin
      cnv_cmplt = 1'b1; res = resp_val; resp_pend = 0;
    end else if (stray_v || (rand_mode && !inflight && $urandom_range(19) == 0)) begin
      cnv_cmplt = 1'b1; res = 12'($urandom);
    end
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_strts(input int n, input int budget);
    int k = 0;
    while (strt_log.size() < n && k < budget) begin tick(); k++; end
    check("wait_strts", 32'(strt_log.size()), 32'(n));
  endtask

  task automatic wait_ch(input int ch, input int budget);
    int n0 = strt_log.size();
    int k = 0;
    bit hit = 0;
    while (!hit && k < budget) begin
      tick(); k++;
      if (strt_log.size() > n0) begin
        if (strt_log[$] == ch) hit = 1;
        n0 = strt_log.size();
      end
    end
    check("wait_ch", 32'(hit), 32'd1);
  endtask

  initial begin
    int sw_exp [7] = '{1, 0, 4, 2, 3, 7, 1};
    int k, r, ls;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    rc = cyc;
    check("rst_chnnl", 32'(chnnl), 32'd0);
    check("rst_vld", 32'(pots_vld), 32'd0);

    // Full sweep with res = channel number
    wait_strts(6, 2000);
    check("vld_before_vol", 32'(pots_vld), 32'd0);
    wait_strts(7, 2000);
    check("first_strt_delay", 32'(strt_cyc_log[0] - rc), 32'(G));
    for (int i = 0; i < 7; i++) check("sweep_order", 32'(strt_log[i]), 32'(sw_exp[i]));
    check("LP_lit", 32'(LP_gain), 32'd1);
    check("B1_lit", 32'(B1_gain), 32'd0);
    check("B2_lit", 32'(B2_gain), 32'd4);
    check("B3_lit", 32'(B3_gain), 32'd2);
    check("HP_lit", 32'(HP_gain), 32'd3);
    check("VOL_lit", 32'(VOLUME), 32'd7);
    check("vld_after_vol", 32'(pots_vld), 32'd1);

    // Aux request during a pot WAIT; a second one while busy must be dropped
    repeat (5) tick();
    aux_chnnl = 3'd5; aux_req = 1'b1; tick();
    aux_chnnl = 3'd6; tick();
    aux_req = 1'b0;
    wait_strts(9, 2000);
    check("aux_slot_ch", 32'(strt_log[7]), 32'd5);
    check("aux_resume_ch", 32'(strt_log[8]), 32'd0);
    check("aux_res_5", 32'(aux_res), 32'd5);

    // Back-to-back aux: re-request right after aux_done
    repeat (5) tick();
    aux_chnnl = 3'd6; aux_req = 1'b1; tick();
    aux_req = 1'b0;
    k = 0;
    while (!saw_done && k < 2000) begin tick(); k++; end
    check("wait_aux_done", 32'(saw_done), 32'd1);
    aux_chnnl = 3'd3; aux_req = 1'b1; tick();
    aux_req = 1'b0;
    check("aux_res_6", 32'(aux_res), 32'd6);
    wait_strts(12, 2000);
    check("b2b_aux1", 32'(strt_log[9]), 32'd6);
    check("b2b_pot", 32'(strt_log[10]), 32'd4);
    check("b2b_aux2", 32'(strt_log[11]), 32'd3);

    // Timeout on channel 4, then retry of the same channel
    silent_ch = 4;
    wait_ch(4, 3000);
    r = strt_cyc_log[$];
    while (cyc < r + T) tick();
    check("err_before_to", 32'(a2d_err), 32'd0);
    tick();
    check("err_after_to", 32'(a2d_err), 32'd1);
    check("B2_unchanged", 32'(B2_gain), 32'd4);
    silent_ch = 8;
    ls = strt_log.size();
    wait_strts(ls + 1, 2000);
    check("retry_ch", 32'(strt_log[$]), 32'd4);

    // Reset while channel 2 is in flight; stale completion lands in GAP
    wait_ch(2, 3000);
    repeat (2) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    rc = cyc;
    resp_pend = 1; resp_cyc = cyc + 2; resp_val = 12'hABC;
    ls = strt_log.size();
    tick();
    check("rst2_LP", 32'(LP_gain), 32'd0);
    check("rst2_VOL", 32'(VOLUME), 32'd0);
    check("rst2_auxres", 32'(aux_res), 32'd0);
    check("rst2_vld", 32'(pots_vld), 32'd0);
    check("rst2_err", 32'(a2d_err), 32'd0);
    check("rst2_busy", 32'(aux_busy), 32'd0);
    check("rst2_chnnl", 32'(chnnl), 32'd0);
    repeat (3) tick();
    stray_v = 1; tick(); stray_v = 0;
    tick();
    check("stray_LP", 32'(LP_gain), 32'd0);
    check("stray_nostrt", 32'(strt_log.size()), 32'(ls));
    wait_strts(ls + 1, 2000);
    check("rst2_first_delay", 32'(strt_cyc_log[$] - rc), 32'(G));
    check("rst2_first_ch", 32'(strt_log[$]), 32'd1);

    // Randomized traffic: aux requests, random latency, drops, strays, rare resets
    rand_mode = 1;
    for (int i = 0; i < 5000; i++) begin
      aux_req   = ($urandom_range(39) == 0);
      aux_chnnl = 3'($urandom);
      rst       = ($urandom_range(2499) == 0);
      tick();
    end
    aux_req = 1'b0; rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
